// File: rtl/m68k_bus_initiator_if.sv
// Request/response and 68040 bus signals of the bus initiator.
// master: the initiator side; slave: the requester/responder side.
interface m68k_bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_siz;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        rsp_last;
    logic [31:0] a;
    logic [31:0] d_out;
    logic        d_oe;
    logic [31:0] d_in;
    logic        rw;
    logic [1:0]  siz;
    logic [1:0]  tt;
    logic [2:0]  tm;
    logic        ts_n;
    logic        tip_n;
    logic        ta_n;
    logic        tea_n;

    modport master (
        input  req_valid, req_addr, req_rw, req_siz, req_wdata, d_in, ta_n, tea_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_last,
               a, d_out, d_oe, rw, siz, tt, tm, ts_n, tip_n
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_siz, req_wdata, d_in, ta_n, tea_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_last,
               a, d_out, d_oe, rw, siz, tt, tm, ts_n, tip_n
    );
endinterface

// File: rtl/m68k_bus_initiator.sv
// 68040-style synchronous bus master: turns single request/response transactions
// into ts_n/tip_n bus cycles terminated by ta_n, tea_n or a DATA-phase timeout.
// Optional feature macro: M68K_INIT_BURST_EN enables 4-beat line transfers for
// siz=11; without it, line requests are rejected with rsp_err and never reach the bus.
module m68k_bus_initiator #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [2:0]  TM_VAL  = 3'b101
) (
    input  logic                        clk,
    input  logic                        rst,
    m68k_bus_initiator_if.master        bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

    state_t          state;
    logic [CntW-1:0] tmo_cnt;
    logic [1:0]      beat;
    logic            burst;
    logic            line_req;
    logic            reject;
    logic            tmo_hit;

`ifdef M68K_INIT_BURST_EN
    assign line_req = (bus.req_siz == 2'b11);
    assign reject   = 1'b0;
`else
    assign line_req = 1'b0;
    assign reject   = (bus.req_siz == 2'b11);
`endif

    // This DATA cycle is the last one allowed without an acknowledge.
    assign tmo_hit = (tmo_cnt == CntW'(TIMEOUT - 1));

    assign bus.req_ready = (state == StIdle);
    assign bus.tt        = 2'b00;
    assign bus.tm        = TM_VAL;

    // Bus-cycle FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= StIdle;
            tmo_cnt         <= '0;
            beat            <= 2'd0;
            burst           <= 1'b0;
            bus.ts_n        <= 1'b1;
            bus.tip_n       <= 1'b1;
            bus.d_oe        <= 1'b0;
            bus.rw          <= 1'b1;
            bus.siz         <= 2'b00;
            bus.a           <= 32'h0;
            bus.d_out       <= 32'h0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= 32'h0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_last    <= 1'b0;
        end else begin
            // Response flags are single-cycle pulses unless set below.
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_last    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        if (reject) begin
                            state         <= StResp;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_last  <= 1'b1;
                        end else begin
                            state     <= StAddr;
                            burst     <= line_req;
                            beat      <= 2'd0;
                            bus.ts_n  <= 1'b0;
                            bus.tip_n <= 1'b0;
                            bus.a     <= line_req ? {bus.req_addr[31:4], 4'h0} : bus.req_addr;
                            bus.rw    <= bus.req_rw;
                            bus.siz   <= bus.req_siz;
                            bus.d_out <= bus.req_wdata;
                            bus.d_oe  <= ~bus.req_rw;
                        end
                    end
                end
                StAddr: begin
                    state    <= StData;
                    tmo_cnt  <= '0;
                    bus.ts_n <= 1'b1;
                end
                StData: begin
                    if (!bus.tea_n) begin
                        // Error wins over a simultaneous ta_n; no data captured.
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_last  <= 1'b1;
                        bus.tip_n     <= 1'b1;
                        bus.d_oe      <= 1'b0;
                        state         <= burst ? StIdle : StResp;
                    end else if (!bus.ta_n) begin
                        bus.rsp_valid <= 1'b1;
                        if (bus.rw) begin
                            bus.rsp_rdata <= bus.d_in;
                        end
                        if (burst && (beat != 2'd3)) begin
                            // Mid-burst beat: stay in DATA, next beat gets a fresh budget.
                            beat      <= beat + 2'd1;
                            tmo_cnt   <= '0;
                            bus.d_out <= bus.req_wdata;
                        end else begin
                            bus.rsp_last <= 1'b1;
                            bus.tip_n    <= 1'b1;
                            bus.d_oe     <= 1'b0;
                            state        <= burst ? StIdle : StResp;
                        end
                    end else if (tmo_hit) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_last    <= 1'b1;
                        bus.tip_n       <= 1'b1;
                        bus.d_oe        <= 1'b0;
                        state           <= burst ? StIdle : StResp;
                    end else begin
                        tmo_cnt <= tmo_cnt + CntW'(1);
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed self-checking bench for m68k_bus_initiator (TIMEOUT overridden to 8).
module tb_m68k_bus_initiator;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic saw_valid;

    m68k_bus_initiator_if bus();

    m68k_bus_initiator #(
        .TIMEOUT (8),
        .TM_VAL  (3'b101)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic rw_i, input logic [1:0] sz,
                           input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_rw    = rw_i;
        bus.req_siz   = sz;
        bus.req_wdata = wd;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_rw    = 1'b1;
        bus.req_siz   = 2'b00;
        bus.req_wdata = 32'h0;
        bus.d_in      = 32'h0;
        bus.ta_n      = 1'b1;
        bus.tea_n     = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();

        // Reset state
        check("rst_ready", 32'(bus.req_ready), 32'h1);
        check("rst_ts_n", 32'(bus.ts_n), 32'h1);
        check("rst_tip_n", 32'(bus.tip_n), 32'h1);
        check("rst_d_oe", 32'(bus.d_oe), 32'h0);
        check("rst_rw", 32'(bus.rw), 32'h1);
        check("rst_a", bus.a, 32'h0);
        check("rst_d_out", bus.d_out, 32'h0);
        check("rst_valid", 32'(bus.rsp_valid), 32'h0);

        // Read, ta_n on the second DATA cycle
        request(32'h0000_1000, 1'b1, 2'b00, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check("rd_addr_ts_n", 32'(bus.ts_n), 32'h0);
        check("rd_addr_tip_n", 32'(bus.tip_n), 32'h0);
        check("rd_addr_a", bus.a, 32'h0000_1000);
        check("rd_addr_ready", 32'(bus.req_ready), 32'h0);
        check("rd_tm", 32'(bus.tm), 32'h5);
        check("rd_tt", 32'(bus.tt), 32'h0);
        step();
        check("rd_d1_ts_n", 32'(bus.ts_n), 32'h1);
        check("rd_d1_tip_n", 32'(bus.tip_n), 32'h0);
        step();
        check("rd_d2_valid", 32'(bus.rsp_valid), 32'h0);
        bus.ta_n = 1'b0;
        bus.d_in = 32'hDEAD_BEEF;
        step();
        bus.ta_n = 1'b1;
        check("rd_resp_valid", 32'(bus.rsp_valid), 32'h1);
        check("rd_resp_data", bus.rsp_rdata, 32'hDEAD_BEEF);
        check("rd_resp_err", 32'(bus.rsp_err), 32'h0);
        check("rd_resp_last", 32'(bus.rsp_last), 32'h1);
        step();
        check("rd_after_valid", 32'(bus.rsp_valid), 32'h0);
        check("rd_after_tip_n", 32'(bus.tip_n), 32'h1);
        check("rd_after_ready", 32'(bus.req_ready), 32'h1);

        // Write, ta_n on the first DATA cycle
        request(32'h3000_0004, 1'b0, 2'b10, 32'h0000_A5A5);
        step();
        bus.req_valid = 1'b0;
        check("wr_addr_rw", 32'(bus.rw), 32'h0);
        check("wr_addr_dout", bus.d_out, 32'h0000_A5A5);
        check("wr_addr_doe", 32'(bus.d_oe), 32'h1);
        check("wr_addr_siz", 32'(bus.siz), 32'h2);
        check("wr_addr_a", bus.a, 32'h3000_0004);
        step();
        check("wr_data_doe", 32'(bus.d_oe), 32'h1);
        bus.ta_n = 1'b0;
        step();
        bus.ta_n = 1'b1;
        check("wr_resp_valid", 32'(bus.rsp_valid), 32'h1);
        check("wr_resp_doe", 32'(bus.d_oe), 32'h0);
        check("wr_resp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        step();

        // ta_n and tea_n together: error wins, read data not captured
        request(32'h2000_0000, 1'b1, 2'b00, 32'h0);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.ta_n  = 1'b0;
        bus.tea_n = 1'b0;
        bus.d_in  = 32'h1234_5678;
        step();
        bus.ta_n  = 1'b1;
        bus.tea_n = 1'b1;
        check("tea_valid", 32'(bus.rsp_valid), 32'h1);
        check("tea_err", 32'(bus.rsp_err), 32'h1);
        check("tea_timeout", 32'(bus.rsp_timeout), 32'h0);
        check("tea_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        step();
        check("tea_after_err", 32'(bus.rsp_err), 32'h0);

        // No acknowledge: timeout after 8 DATA cycles
        request(32'h5000_0000, 1'b1, 2'b00, 32'h0);
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("tmo_d8_tip_n", 32'(bus.tip_n), 32'h0);
        check("tmo_d8_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        check("tmo_valid", 32'(bus.rsp_valid), 32'h1);
        check("tmo_flag", 32'(bus.rsp_timeout), 32'h1);
        check("tmo_err", 32'(bus.rsp_err), 32'h0);
        check("tmo_tip_n", 32'(bus.tip_n), 32'h1);
        step();
        check("tmo_ready", 32'(bus.req_ready), 32'h1);
        request(32'h0000_2000, 1'b1, 2'b00, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check("post_tmo_ts_n", 32'(bus.ts_n), 32'h0);
        step();
        bus.ta_n = 1'b0;
        bus.d_in = 32'hCAFE_F00D;
        step();
        bus.ta_n = 1'b1;
        check("post_tmo_data", bus.rsp_rdata, 32'hCAFE_F00D);
        step();

        // Reset asserted during DATA of a write
        request(32'h3000_0010, 1'b0, 2'b00, 32'h5555_AAAA);
        step();
        bus.req_valid = 1'b0;
        step();
        check("mid_doe_before", 32'(bus.d_oe), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_tip_n", 32'(bus.tip_n), 32'h1);
        check("mid_rst_doe", 32'(bus.d_oe), 32'h0);
        check("mid_rst_ts_n", 32'(bus.ts_n), 32'h1);
        step();
        bus.ta_n = 1'b0;
        step();
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        bus.ta_n = 1'b1;
        check("mid_rst_no_valid", 32'(saw_valid), 32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h1);

`ifdef M68K_INIT_BURST_EN
        // Line read: four beats, rsp_last on the fourth
        request(32'h0000_0008, 1'b1, 2'b11, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check("ln_a", bus.a, 32'h0000_0000);
        check("ln_siz", 32'(bus.siz), 32'h3);
        step();
        bus.ta_n = 1'b0;
        bus.d_in = 32'h11;
        step();
        check("ln_b1_valid", 32'(bus.rsp_valid), 32'h1);
        check("ln_b1_data", bus.rsp_rdata, 32'h11);
        check("ln_b1_last", 32'(bus.rsp_last), 32'h0);
        bus.d_in = 32'h22;
        step();
        check("ln_b2_data", bus.rsp_rdata, 32'h22);
        check("ln_b2_last", 32'(bus.rsp_last), 32'h0);
        bus.d_in = 32'h33;
        step();
        check("ln_b3_data", bus.rsp_rdata, 32'h33);
        check("ln_b3_last", 32'(bus.rsp_last), 32'h0);
        bus.d_in = 32'h44;
        step();
        bus.ta_n = 1'b1;
        check("ln_b4_valid", 32'(bus.rsp_valid), 32'h1);
        check("ln_b4_data", bus.rsp_rdata, 32'h44);
        check("ln_b4_last", 32'(bus.rsp_last), 32'h1);
        check("ln_b4_tip_n", 32'(bus.tip_n), 32'h1);
        step();
        check("ln_end_valid", 32'(bus.rsp_valid), 32'h0);
        check("ln_end_ready", 32'(bus.req_ready), 32'h1);

        // Line read aborted by tea_n on beat 2
        request(32'h3000_0020, 1'b1, 2'b11, 32'h0);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.ta_n = 1'b0;
        bus.d_in = 32'h11;
        step();
        check("lnab_b1_last", 32'(bus.rsp_last), 32'h0);
        bus.ta_n  = 1'b1;
        bus.tea_n = 1'b0;
        step();
        bus.tea_n = 1'b1;
        check("lnab_valid", 32'(bus.rsp_valid), 32'h1);
        check("lnab_err", 32'(bus.rsp_err), 32'h1);
        check("lnab_last", 32'(bus.rsp_last), 32'h1);
        check("lnab_tip_n", 32'(bus.tip_n), 32'h1);
        step();
        check("lnab_idle_valid", 32'(bus.rsp_valid), 32'h0);
`else
        // Line request rejected without touching the bus
        request(32'h0000_0008, 1'b1, 2'b11, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check("ln_rej_valid", 32'(bus.rsp_valid), 32'h1);
        check("ln_rej_err", 32'(bus.rsp_err), 32'h1);
        check("ln_rej_last", 32'(bus.rsp_last), 32'h1);
        check("ln_rej_ts_n", 32'(bus.ts_n), 32'h1);
        check("ln_rej_tip_n", 32'(bus.tip_n), 32'h1);
        step();
        check("ln_rej_idle_valid", 32'(bus.rsp_valid), 32'h0);
        check("ln_rej_idle_ts_n", 32'(bus.ts_n), 32'h1);
        check("ln_rej_ready", 32'(bus.req_ready), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
